// File: rtl/shift_register_capture.sv
// ---------------------------------------------------------------------------
// shift_register_capture
//
// Serial-to-parallel frame capture. A one-cycle start strobe opens a frame.
// N data bits then arrive LSB first on SI, each one qualified by shift_en.
// Gaps of any length between bits are allowed. When the Nth bit is sampled,
// the assembled word is loaded into Q and valid pulses for one cycle.
//
// Parameters:
//   N        frame width in bits (N >= 2)
//
// Ports:
//   clk      system clock; all state changes on the rising edge
//   reset    synchronous active-high reset
//   SI       serial data in, LSB first
//   start    one-cycle frame-start strobe; only honoured while idle
//   shift_en bit strobe; SI carries a valid bit in cycles where it is high
//   Q        last completed parallel word (registered)
//   valid    one-cycle pulse marking a new word on Q
//   busy     high while a frame is being captured
// ---------------------------------------------------------------------------
module shift_register_capture #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         SI,
  input  logic         start,
  input  logic         shift_en,
  output logic [N-1:0] Q,
  output logic         valid,
  output logic         busy
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [N-1:0]    sr_r;
  logic [N-1:0]    sr_next_s;
  logic            last_bit_s;

  // Right shift: the newest bit enters at the MSB, so after N bits the
  // first-received bit has reached bit 0 (LSB-first framing).
  assign sr_next_s  = {SI, sr_r[N-1:1]};
  assign last_bit_s = (cnt_r == LAST_CNT);

  // Frame FSM with registered Q/valid/busy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      sr_r    <= {N{1'b0}};
      Q       <= {N{1'b0}};
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      // valid is a single-cycle pulse unless set again below
      valid <= 1'b0;
      case (state_r)
        IDLE: begin
          // SI and shift_en are ignored on the accepting edge
          if (start) begin
            state_r <= SHIFT;
            cnt_r   <= {CW{1'b0}};
            sr_r    <= {N{1'b0}};
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        SHIFT: begin
          // start is deliberately ignored here: no restart mid-frame
          if (shift_en) begin
            sr_r <= sr_next_s;
            if (last_bit_s) begin
              Q       <= sr_next_s;
              valid   <= 1'b1;
              state_r <= IDLE;
              busy    <= 1'b0;
              cnt_r   <= {CW{1'b0}};
            end else begin
              cnt_r   <= cnt_r + CW'(1);
            end
          end else begin
            cnt_r <= cnt_r;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= {CW{1'b0}};
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_register_capture.sv
// ---------------------------------------------------------------------------
// tb_shift_register_capture
//
// Directed self-checking bench for shift_register_capture with N=4.
// Inputs change 1 time unit after the rising edge; outputs are sampled at
// that same point, i.e. away from the active edge.
// ---------------------------------------------------------------------------
module tb_shift_register_capture;

  localparam int N = 4;

  logic         clk;
  logic         reset;
  logic         SI;
  logic         start;
  logic         shift_en;
  logic [N-1:0] Q;
  logic         valid;
  logic         busy;

  int tests;
  int fails;
  int vcnt;     // valid pulses observed
  int bcnt;     // cycles with busy high observed

  shift_register_capture #(.N(N)) dut (
    .clk      (clk),
    .reset    (reset),
    .SI       (SI),
    .start    (start),
    .shift_en (shift_en),
    .Q        (Q),
    .valid    (valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge, then settle and tally pulse counters.
  task automatic tick();
    @(posedge clk);
    #1;
    if (valid === 1'b1) vcnt = vcnt + 1;
    if (busy === 1'b1) bcnt = bcnt + 1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests = tests + 1;
    assert (obs === exp) else begin
      fails = fails + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    SI       = b;
    shift_en = 1'b1;
    tick();
    shift_en = 1'b0;
    SI       = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  int v0;

  initial begin
    tests    = 0;
    fails    = 0;
    vcnt     = 0;
    bcnt     = 0;
    reset    = 1'b1;
    SI       = 1'b0;
    start    = 1'b0;
    shift_en = 1'b0;
    #1;
    tick();
    tick();
    chk("reset_Q", 32'(Q), 32'h0);
    chk("reset_valid", 32'(valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    reset = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'h0);

    // basic: bits 1,1,0,1 -> 4'b1011
    vcnt = 0;
    bcnt = 0;
    do_start();
    chk("basic_busy_after_start", 32'(busy), 32'h1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("basic_Q_partial", 32'(Q), 32'h0);
    chk("basic_valid_partial", 32'(valid), 32'h0);
    send_bit(1'b1);
    chk("basic_Q", 32'(Q), 32'hB);
    chk("basic_valid", 32'(valid), 32'h1);
    chk("basic_busy_done", 32'(busy), 32'h0);
    tick();
    chk("basic_valid_one_cycle", 32'(valid), 32'h0);
    chk("basic_Q_hold", 32'(Q), 32'hB);
    chk("basic_busy_cycles", 32'(bcnt), 32'd4);
    chk("basic_pulses", 32'(vcnt), 32'd1);

    // gapped strobes: 3 idle cycles before each bit
    vcnt = 0;
    do_start();
    idle(3); send_bit(1'b1);
    idle(3); send_bit(1'b1);
    idle(3); send_bit(1'b0);
    chk("gap_Q_hold", 32'(Q), 32'hB);
    chk("gap_busy_mid", 32'(busy), 32'h1);
    chk("gap_no_early_valid", 32'(vcnt), 32'd0);
    idle(3); send_bit(1'b1);
    chk("gap_Q", 32'(Q), 32'hB);
    chk("gap_valid", 32'(valid), 32'h1);

    // back-to-back: start during the valid cycle, bits 0,1,0,0 -> 4'b0010
    vcnt = 0;
    do_start();
    chk("b2b_busy", 32'(busy), 32'h1);
    chk("b2b_valid_low", 32'(valid), 32'h0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    chk("b2b_Q_hold", 32'(Q), 32'hB);
    send_bit(1'b0);
    chk("b2b_Q", 32'(Q), 32'h2);
    chk("b2b_valid", 32'(valid), 32'h1);
    tick();
    chk("b2b_pulses", 32'(vcnt), 32'd1);

    // start while busy: no restart
    vcnt = 0;
    do_start();
    send_bit(1'b1);
    send_bit(1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("sbusy_busy", 32'(busy), 32'h1);
    send_bit(1'b0);
    chk("sbusy_no_early", 32'(vcnt), 32'd0);
    send_bit(1'b1);
    chk("sbusy_Q", 32'(Q), 32'hB);
    chk("sbusy_valid", 32'(valid), 32'h1);
    tick();

    // reset mid-frame, then stray strobes in IDLE, then full frame 1,0,0,1
    vcnt = 0;
    do_start();
    send_bit(1'b1);
    send_bit(1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rmid_Q", 32'(Q), 32'h0);
    chk("rmid_busy", 32'(busy), 32'h0);
    chk("rmid_valid", 32'(valid), 32'h0);
    send_bit(1'b1);
    send_bit(1'b1);
    tick();
    chk("rmid_no_valid", 32'(vcnt), 32'd0);
    chk("rmid_idle_Q", 32'(Q), 32'h0);
    do_start();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    chk("rmid_Q_new", 32'(Q), 32'h9);
    chk("rmid_valid_new", 32'(valid), 32'h1);
    tick();

    // reset and start on the same edge: reset wins
    v0 = vcnt;
    reset = 1'b1;
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    chk("rstart_busy", 32'(busy), 32'h0);
    chk("rstart_Q", 32'(Q), 32'h0);
    send_bit(1'b1);
    chk("rstart_busy2", 32'(busy), 32'h0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    tick();
    chk("rstart_no_valid", 32'(vcnt - v0), 32'd0);
    chk("rstart_Q_hold", 32'(Q), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
